decode_stage: RTL and testbench

Parametrised, registered RV32 decode stage for the in-order pipeline, sitting between fetch and execute. It owns the architectural register file, generates immediates for all base formats, and tracks pending register writes in a scoreboard to stall RAW/WAW hazards. It presents a one-entry valid/ready output register to execute, with optional writeback-to-read bypass.

---
 rtl/decode_stage_if.sv | 41 ++++
 rtl/decode_stage.sv | 107 ++++++++++
 tb/tb_decode_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch, writeback and execute-facing signals of the decode stage
interface decode_stage_if #(
  parameter int XLEN = 32,
  parameter int NUM_REGS = 32
);
  logic in_valid;
  logic in_ready;
  logic [31:0] in_instruction;
  logic [XLEN-1:0] in_pc;
  logic flush;
  logic [NUM_REGS-1:0] sb_clear;
  logic write_enable;
  logic [4:0] write_destination;
  logic [XLEN-1:0] write_data;
  logic out_valid;
  logic out_ready;
  logic [6:0] out_op;
  logic [2:0] out_funct3;
  logic [6:0] out_funct7;
  logic [4:0] out_rd;
  logic [4:0] out_rs1;
  logic [4:0] out_rs2;
  logic out_rd_write;
  logic [XLEN-1:0] out_source_data1;
  logic [XLEN-1:0] out_source_data2;
  logic [XLEN-1:0] out_store_data;
  logic [XLEN-1:0] out_imm;
  logic out_use_imm;
  logic [XLEN-1:0] out_pc;
  logic out_illegal;
  modport master (
    output in_valid, in_instruction, in_pc, flush, sb_clear, write_enable, write_destination, write_data, out_ready,
    input in_ready, out_valid, out_op, out_funct3, out_funct7, out_rd, out_rs1, out_rs2, out_rd_write,
    out_source_data1, out_source_data2, out_store_data, out_imm, out_use_imm, out_pc, out_illegal
  );
  modport slave (
    input in_valid, in_instruction, in_pc, flush, sb_clear, write_enable, write_destination, write_data, out_ready,
    output in_ready, out_valid, out_op, out_funct3, out_funct7, out_rd, out_rs1, out_rs2, out_rd_write,
    out_source_data1, out_source_data2, out_store_data, out_imm, out_use_imm, out_pc, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32 decode with register file, scoreboard hazard stall and registered output
module decode_stage #(
  parameter int XLEN = 32,
  parameter int NUM_REGS = 32,
  parameter bit BYPASS = 1'b1
) (
  input logic clock,
  input logic reset,
  decode_stage_if.slave d
);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67, BRANCH = 7'h63,
    LOAD = 7'h03, STORE = 7'h23, OPIMM = 7'h13, OP = 7'h33, MISC = 7'h0F, SYS = 7'h73;
  logic [31:0] ins;
  logic [6:0] op;
  logic [4:0] rd, rs1, rs2;
  logic [31:0] imm32;
  logic [XLEN-1:0] imm, sd1, sd2;
  logic known, use1, use2, wr, use_imm, big, illegal, rd_write, hazard, accept;
  logic [NUM_REGS-1:0] sb, pend, wclr, fclr, set;
  logic [XLEN-1:0] rf [NUM_REGS];
  assign ins = d.in_instruction;
  assign op = ins[6:0];
  assign rd = ins[11:7];
  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];
  function automatic logic oor(input logic [4:0] i);
    return NUM_REGS < 32 && i[4];
  endfunction
  function automatic logic [NUM_REGS-1:0] oh(input logic [4:0] i);
    return oor(i) ? '0 : NUM_REGS'(1) << i[IW-1:0];
  endfunction
  function automatic logic [XLEN-1:0] rd_reg(input logic [4:0] i);
    return (i == 5'd0 || oor(i)) ? '0 :
      (BYPASS && d.write_enable && d.write_destination == i) ? d.write_data : rf[i[IW-1:0]];
  endfunction
  // classify the opcode, build the immediate and decide legality and hazards
  always_comb begin
    known = op inside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, MISC, SYS};
    use1 = op inside {JALR, BRANCH, LOAD, STORE, OPIMM, OP};
    use2 = op inside {BRANCH, STORE, OP};
    wr = op inside {LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP} && rd != 5'd0;
    use_imm = op inside {LUI, AUIPC, JAL, JALR, LOAD, STORE, OPIMM};
    imm32 = op inside {LUI, AUIPC} ? {ins[31:12], 12'b0} :
      op == JAL ? {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0} :
      op inside {JALR, LOAD, OPIMM, MISC, SYS} ? {{20{ins[31]}}, ins[31:20]} :
      op == STORE ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
      op == BRANCH ? {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0} : 32'd0;
    imm = XLEN'($signed(imm32));
    big = (use1 && oor(rs1)) || (use2 && oor(rs2)) || (wr && oor(rd));
    illegal = !known || big;
    rd_write = wr && !illegal;
    sd1 = rd_reg(rs1);
    sd2 = rd_reg(rs2);
    wclr = (d.write_enable && d.write_destination != 5'd0) ? oh(d.write_destination) : '0;
    pend = BYPASS ? sb & ~wclr : sb;
    hazard = !illegal && ((use1 && pend[rs1[IW-1:0]]) || (use2 && pend[rs2[IW-1:0]]) || (rd_write && pend[rd[IW-1:0]]));
    d.in_ready = (!d.out_valid || d.out_ready) && !hazard && !d.flush;
    accept = d.in_valid && d.in_ready;
    fclr = (d.flush && d.out_valid && d.out_rd_write) ? oh(d.out_rd) : '0;
    set = (accept && rd_write) ? oh(rd) : '0;
  end
  // register file write port; x0 and out-of-range destinations are dropped
  always_ff @(posedge clock or posedge reset)
    if (reset) for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    else if (d.write_enable && d.write_destination != 5'd0 && !oor(d.write_destination))
      rf[d.write_destination[IW-1:0]] <= d.write_data;
  // pending-write scoreboard; a new set wins over any clear on the same bit
  always_ff @(posedge clock or posedge reset)
    if (reset) sb <= '0;
    else sb <= (sb & ~(wclr | d.sb_clear | fclr)) | set;
  // one-entry output register toward execute
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      d.out_valid <= 1'b0;
      d.out_op <= '0;
      d.out_funct3 <= '0;
      d.out_funct7 <= '0;
      d.out_rd <= '0;
      d.out_rs1 <= '0;
      d.out_rs2 <= '0;
      d.out_rd_write <= 1'b0;
      d.out_source_data1 <= '0;
      d.out_source_data2 <= '0;
      d.out_store_data <= '0;
      d.out_imm <= '0;
      d.out_use_imm <= 1'b0;
      d.out_pc <= '0;
      d.out_illegal <= 1'b0;
    end else if (accept) begin
      d.out_valid <= 1'b1;
      d.out_op <= op;
      d.out_funct3 <= ins[14:12];
      d.out_funct7 <= ins[31:25];
      d.out_rd <= rd;
      d.out_rs1 <= rs1;
      d.out_rs2 <= rs2;
      d.out_rd_write <= rd_write;
      d.out_source_data1 <= sd1;
      d.out_source_data2 <= use_imm ? imm : sd2;
      d.out_store_data <= sd2;
      d.out_imm <= imm;
      d.out_use_imm <= use_imm;
      d.out_pc <= d.in_pc;
      d.out_illegal <= illegal;
    end else if (d.flush || d.out_ready) d.out_valid <= 1'b0;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors for the decode stage in bypass/RV32I and no-bypass/RV32E builds
module tb_decode_stage;
  logic clock = 1'b0;
  logic reset;
  int n_vec = 0;
  int n_err = 0;
  decode_stage_if #(.XLEN(32), .NUM_REGS(32)) a ();
  decode_stage_if #(.XLEN(32), .NUM_REGS(16)) b ();
  decode_stage #(.XLEN(32), .NUM_REGS(32), .BYPASS(1'b1)) u_a (.clock(clock), .reset(reset), .d(a));
  decode_stage #(.XLEN(32), .NUM_REGS(16), .BYPASS(1'b0)) u_b (.clock(clock), .reset(reset), .d(b));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b1;
    {a.in_valid, a.in_instruction, a.in_pc, a.flush, a.sb_clear, a.write_enable, a.write_destination, a.write_data, a.out_ready} = '0;
    {b.in_valid, b.in_instruction, b.in_pc, b.flush, b.sb_clear, b.write_enable, b.write_destination, b.write_data, b.out_ready} = '0;
    #12;
    chk("rst_valid", a.out_valid, 0);
    chk("rst_imm", a.out_imm, 0);
    chk("rst_pc", a.out_pc, 0);
    chk("rst_ready", a.in_ready, 1);
    reset = 1'b0;
    cyc();
    a.out_ready = 1;
    a.in_valid = 1; a.in_instruction = 32'h00500093; a.in_pc = 32'h100;
    #1 chk("addi_ready", a.in_ready, 1);
    cyc();
    chk("addi_valid", a.out_valid, 1);
    chk("addi_imm", a.out_imm, 5);
    chk("addi_use_imm", a.out_use_imm, 1);
    chk("addi_rd_write", a.out_rd_write, 1);
    chk("addi_rd", a.out_rd, 1);
    chk("addi_pc", a.out_pc, 32'h100);
    a.in_instruction = 32'h002081B3; a.in_pc = 32'h104;
    #1 chk("add_stall0", a.in_ready, 0);
    cyc();
    chk("add_drained", a.out_valid, 0);
    chk("add_stall1", a.in_ready, 0);
    a.write_enable = 1; a.write_destination = 1; a.write_data = 5;
    #1 chk("add_bypass_ready", a.in_ready, 1);
    cyc();
    a.write_enable = 0;
    chk("add_valid", a.out_valid, 1);
    chk("add_src1", a.out_source_data1, 5);
    chk("add_src2", a.out_source_data2, 0);
    chk("add_rd", a.out_rd, 3);
    chk("add_use_imm", a.out_use_imm, 0);
    a.in_instruction = 32'hFE000EE3; a.in_pc = 32'h108;
    #1 chk("beq_ready", a.in_ready, 1);
    cyc();
    chk("beq_imm", a.out_imm, 32'hFFFFFFFC);
    chk("beq_use_imm", a.out_use_imm, 0);
    chk("beq_rd_write", a.out_rd_write, 0);
    a.in_instruction = 32'h123452B7; a.in_pc = 32'h10C;
    cyc();
    chk("lui_imm", a.out_imm, 32'h12345000);
    chk("lui_rd_write", a.out_rd_write, 1);
    chk("lui_rd", a.out_rd, 5);
    a.in_valid = 0; a.in_instruction = 32'h00128313;
    #1 chk("x5_pending", a.in_ready, 0);
    a.flush = 1;
    #1 chk("flush_ready", a.in_ready, 0);
    cyc();
    a.flush = 0;
    chk("flush_valid", a.out_valid, 0);
    #1 chk("x5_cleared", a.in_ready, 1);
    a.in_instruction = 32'h00018233;
    #1 chk("x3_pending", a.in_ready, 0);
    a.sb_clear = 32'h8;
    cyc();
    a.sb_clear = 0;
    #1 chk("x3_sb_clear", a.in_ready, 1);
    a.in_valid = 1; a.in_instruction = 32'h00000FFF; a.in_pc = 32'h110;
    #1 chk("ill_ready", a.in_ready, 1);
    cyc();
    chk("ill_flag", a.out_illegal, 1);
    chk("ill_imm", a.out_imm, 0);
    chk("ill_rd_write", a.out_rd_write, 0);
    a.in_valid = 0; a.in_instruction = 32'h000F8093;
    #1 chk("ill_no_sb_set", a.in_ready, 1);
    cyc();
    a.out_ready = 0;
    a.in_valid = 1; a.in_instruction = 32'h00700393; a.in_pc = 32'h200;
    cyc();
    a.in_instruction = 32'h00800413; a.in_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      chk("hold_ready", a.in_ready, 0);
      chk("hold_pc", a.out_pc, 32'h200);
      chk("hold_imm", a.out_imm, 7);
      cyc();
    end
    a.out_ready = 1;
    #1 chk("release_ready", a.in_ready, 1);
    cyc();
    chk("b2b_pc0", a.out_pc, 32'h204);
    chk("b2b_imm0", a.out_imm, 8);
    a.in_instruction = 32'h00900493; a.in_pc = 32'h208;
    cyc();
    chk("b2b_pc1", a.out_pc, 32'h208);
    chk("b2b_valid1", a.out_valid, 1);
    a.in_instruction = 32'h00500093;
    cyc();
    a.in_instruction = 32'h002081B3;
    #1 chk("rst_stall", a.in_ready, 0);
    reset = 1;
    #1 chk("rst_mid_valid", a.out_valid, 0);
    reset = 0;
    #1 chk("rst_sb_empty", a.in_ready, 1);
    cyc();
    chk("rst_x1_zero", a.out_source_data1, 0);
    chk("rst_add_valid", a.out_valid, 1);
    a.in_valid = 0;
    b.out_ready = 1;
    b.in_valid = 1; b.in_instruction = 32'h00500093;
    #1 chk("e_addi_ready", b.in_ready, 1);
    cyc();
    chk("e_addi_imm", b.out_imm, 5);
    b.in_instruction = 32'h002081B3;
    #1 chk("e_add_stall", b.in_ready, 0);
    b.write_enable = 1; b.write_destination = 1; b.write_data = 5;
    #1 chk("e_no_bypass", b.in_ready, 0);
    cyc();
    b.write_enable = 0;
    #1 chk("e_add_ready", b.in_ready, 1);
    cyc();
    chk("e_add_src1", b.out_source_data1, 5);
    chk("e_add_rd", b.out_rd, 3);
    b.in_instruction = 32'h00100893;
    cyc();
    chk("e_x17_illegal", b.out_illegal, 1);
    chk("e_x17_rd_write", b.out_rd_write, 0);
    b.in_valid = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
